// File: rtl/gcd_feeder_pkg.sv
// rtl/gcd_feeder_pkg.sv - shared types for the GCD job feeder
// Contents: state_t, the job sequencer state encoding.

package gcd_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push_i/data_i    write request and data (ignored when full)
//   pop_i            read request (ignored when empty)
//   data_o           head entry, valid whenever empty_o is low
//   full_o, empty_o  occupancy flags
//   level_o          number of stored entries

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Storage carries no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/gcd_job_feeder.sv
// rtl/gcd_job_feeder.sv - queues operand pairs and runs them one at a time through a GCD core
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_x/in_y   operand pair input stream
//   gcd_go/gcd_x/gcd_y            start pulse and operands to the core
//   gcd_out/gcd_done              core result and completion flag
//   res_valid/res_ready           result output stream handshake
//   res_data/res_err              result (0 on error) and timeout flag
//   fifo_level                    input queue occupancy

module gcd_job_feeder
    import gcd_feeder_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_x,
    input  logic [WIDTH-1:0]           in_y,
    output logic                       gcd_go,
    output logic [WIDTH-1:0]           gcd_x,
    output logic [WIDTH-1:0]           gcd_y,
    input  logic [WIDTH-1:0]           gcd_out,
    input  logic                       gcd_done,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_data,
    output logic                       res_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t               state_q;
    logic [WIDTH-1:0]     op_x_q;
    logic [WIDTH-1:0]     op_y_q;
    logic                 gcd_go_q;
    logic                 res_valid_q;
    logic [WIDTH-1:0]     res_data_q;
    logic                 res_err_q;
    logic [TW-1:0]        timer_q;
    logic [TW-1:0]        timer_d;

    logic [2*WIDTH-1:0]   fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [WIDTH-1:0]     head_x;
    logic [WIDTH-1:0]     head_y;

    sync_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .data_i  ({in_x, in_y}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign head_x   = fifo_head[2*WIDTH-1:WIDTH];
    assign head_y   = fifo_head[WIDTH-1:0];
    assign fifo_pop = (state_q == IDLE) && !fifo_empty;
    assign in_ready = !fifo_full;

    assign gcd_go    = gcd_go_q;
    assign gcd_x     = op_x_q;
    assign gcd_y     = op_y_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

    assign timer_d = (timer_q == TIMER_LAST) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_x_q      <= '0;
            op_y_q      <= '0;
            gcd_go_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            gcd_go_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        op_x_q <= head_x;
                        op_y_q <= head_y;
                        // The core never terminates on a zero operand; the
                        // OR of the pair is the GCD whenever either is zero.
                        if (head_x == '0 || head_y == '0) begin
                            res_data_q  <= head_x | head_y;
                            res_err_q   <= 1'b0;
                            res_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            gcd_go_q <= 1'b1;
                            state_q  <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    timer_q <= timer_d;
                    // timer_q == 0 marks the first WAIT cycle, where done may
                    // still be left over from the previous job.
                    if (timer_q != '0 && gcd_done) begin
                        res_data_q  <= gcd_out;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (timer_q == TIMER_LAST) begin
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_feeder.sv
// tb/tb_gcd_job_feeder.sv - self-checking bench for gcd_job_feeder with a behavioural GCD core

module tb_gcd_job_feeder;

    localparam int WIDTH   = 5;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int LW      = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             gcd_go;
    logic [WIDTH-1:0] gcd_x;
    logic [WIDTH-1:0] gcd_y;
    logic [WIDTH-1:0] gcd_out;
    logic             gcd_done;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic [LW-1:0]    fifo_level;

    gcd_job_feeder #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .gcd_go     (gcd_go),
        .gcd_x      (gcd_x),
        .gcd_y      (gcd_y),
        .gcd_out    (gcd_out),
        .gcd_done   (gcd_done),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    function automatic int ref_gcd(int a, int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Core model: 0 = done after core_lat cycles, 1 = done stuck high with a
    // stale result until the second cycle after go, 2 = never done.
    int               core_mode = 0;
    int               core_lat  = 5;
    int               core_k    = -1;
    logic [WIDTH-1:0] core_x    = '0;
    logic [WIDTH-1:0] core_y    = '0;
    logic [WIDTH-1:0] stale_val = '0;
    int               go_count  = 0;
    int               go_wide   = 0;
    logic             go_prev   = 1'b0;

    always @(negedge clk) begin
        if (gcd_go) go_count++;
        if (gcd_go && go_prev) go_wide++;
        go_prev = gcd_go;
        if (rst) begin
            gcd_done = 1'b0;
            gcd_out  = '0;
            core_k   = -1;
        end else if (gcd_go) begin
            core_x   = gcd_x;
            core_y   = gcd_y;
            gcd_done = (core_mode == 1);
            core_k   = (core_mode == 2) ? -1 : 0;
        end else if (core_k >= 0) begin
            core_k++;
            if (core_mode == 0 && core_k == core_lat) begin
                gcd_done = 1'b1;
                gcd_out  = WIDTH'(ref_gcd(int'(core_x), int'(core_y)));
                core_k   = -1;
            end else if (core_mode == 1 && core_k == 2) begin
                gcd_out  = WIDTH'(ref_gcd(int'(core_x), int'(core_y)));
                core_k   = -1;
            end
        end else if (core_mode == 1) begin
            gcd_done = 1'b1;
            gcd_out  = stale_val;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int x, input int y, output int e);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_ready", in_ready, 1);
        in_valid = 1'b1;
        in_x     = WIDTH'(x);
        in_y     = WIDTH'(y);
        tick();
        e        = cyc;
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input int exp_data, input int exp_err, input int exp_cyc);
        int n;
        n = 0;
        while (!res_valid && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, res_valid, 1);
        if (exp_cyc >= 0) check({tag, "_cycle"}, cyc, exp_cyc);
        check({tag, "_data"}, res_data, exp_data);
        check({tag, "_err"}, res_err, exp_err);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_drop"}, res_valid, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_gcd_go"}, gcd_go, 0);
        check({tag, "_gcd_x"}, gcd_x, 0);
        check({tag, "_gcd_y"}, gcd_y, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_res_err"}, res_err, 0);
        check({tag, "_level"}, fifo_level, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e;
        int g0;
        int seen;
        int x;
        int y;
        int lat;
        int bx[5];
        int by[5];
        int expq[$];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        res_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_values("reset");
        tick();

        // Single nonzero job through the core.
        core_mode = 0;
        core_lat  = 5;
        g0 = go_count;
        push(12, 8, e);
        get_result("single", 4, 0, e + 7);
        check("single_go_pulses", go_count - g0, 1);
        check("single_go_width", go_wide, 0);
        check("single_core_x", core_x, 12);
        check("single_core_y", core_y, 8);

        // Zero operands bypass the core.
        g0 = go_count;
        push(0, 9, e);
        get_result("zero_0_9", 9, 0, e + 1);
        push(0, 0, e);
        get_result("zero_0_0", 0, 0, e + 1);
        check("zero_go_pulses", go_count - g0, 0);

        // Backpressure: queue fills while the first result is held.
        core_lat = 3;
        bx = '{15, 9, 7, 8, 14};
        by = '{10, 6, 7, 4, 21};
        for (int i = 0; i < 5; i++) begin
            push(bx[i], by[i], e);
            expq.push_back(ref_gcd(bx[i], by[i]));
        end
        check("bp_level_full", fifo_level, 4);
        check("bp_in_ready_full", in_ready, 0);
        seen = 0;
        while (!res_valid && seen < 50) begin
            tick();
            seen++;
        end
        check("bp_hold_valid", res_valid, 1);
        check("bp_hold_in_ready", in_ready, 0);
        check("bp_hold_level", fifo_level, 4);
        for (int i = 0; i < 5; i++) begin
            get_result($sformatf("bp_job%0d", i), expq.pop_front(), 0, -1);
        end

        // Stale done held high across a launch.
        core_mode = 1;
        stale_val = 5'd31;
        repeat (2) tick();
        push(6, 4, e);
        get_result("stale_done", 2, 0, e + 4);
        core_mode = 0;

        // Core that never finishes.
        core_mode = 2;
        g0 = go_count;
        push(5, 3, e);
        get_result("timeout", 0, 1, e + 2 + TIMEOUT);
        check("timeout_go_pulses", go_count - g0, 1);
        core_mode = 0;

        // Randomized single jobs, including occasional zero operands.
        for (int i = 0; i < 12; i++) begin
            x   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
            y   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
            lat = $urandom_range(2, 9);
            core_lat = lat;
            repeat ($urandom_range(0, 3)) tick();
            push(x, y, e);
            get_result($sformatf("rand%0d_%0d_%0d", i, x, y), ref_gcd(x, y), 0,
                       (x == 0 || y == 0) ? e + 1 : e + 2 + lat);
        end

        // Reset while waiting on the core with three jobs queued.
        core_mode = 2;
        push(9, 3, e);
        push(4, 2, e);
        push(6, 3, e);
        push(10, 5, e);
        repeat (5) tick();
        check("midreset_level_before", fifo_level, 3);
        check("midreset_gcd_x_before", gcd_x, 9);
        rst = 1'b1;
        tick();
        check_reset_values("midreset");
        rst = 1'b0;
        g0   = go_count;
        seen = 0;
        repeat (80) begin
            tick();
            if (res_valid) seen = 1;
        end
        check("post_reset_no_result", seen, 0);
        check("post_reset_no_go", go_count - g0, 0);
        core_mode = 0;
        core_lat  = 4;
        push(3, 9, e);
        get_result("after_reset", 3, 0, e + 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
